conv_weight_packer: RTL and testbench

- Writer-side companion to the convolution engine's weight fetch.
- Accepts a serial stream of signed 3x3 kernel coefficients over a valid/ready handshake.
- Packs each group of 9 coefficients into one 9*SIZE-bit word, in the exact lane order the convolution engine unpacks (w11 in the low lane, w19 in the high lane).
- Writes the packed words into weight RAM at consecutive addresses from memstartw, and raises STOP when the requested word count has been written.

---
 rtl/conv_weight_packer_if.sv | 30 +++
 rtl/conv_weight_packer.sv | 155 +++++++++++++++
 tb/tb_conv_weight_packer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_weight_packer_if.sv
// Coefficient stream, load control and weight-RAM write bus of the convolution weight packer.
// The master side is the host/stream source; the slave side is the packer.
interface conv_weight_packer_if #(
    parameter int SIZE             = 11,
    parameter int SIZE_9           = 99,
    parameter int SIZE_address_wei = 13,
    parameter int SIZE_cnt         = 10
);
    logic                        load_en;
    logic [SIZE_address_wei-1:0] memstartw;
    logic [SIZE_cnt-1:0]         num_words;
    logic [SIZE-1:0]             in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic                        we_w;
    logic [SIZE_address_wei-1:0] write_addressw;
    logic [SIZE_9-1:0]           dw;
    logic                        STOP;
    logic                        busy;

    modport master (
        output load_en, memstartw, num_words, in_data, in_valid,
        input  in_ready, we_w, write_addressw, dw, STOP, busy
    );

    modport slave (
        input  load_en, memstartw, num_words, in_data, in_valid,
        output in_ready, we_w, write_addressw, dw, STOP, busy
    );
endinterface

// File: rtl/conv_weight_packer.sv
// Packs a serial stream of signed 3x3 kernel coefficients into 9-lane words (w11 in the
// low lane) and writes them to weight RAM at consecutive addresses, raising STOP when done.
module conv_weight_packer #(
    parameter int SIZE             = 11,
    parameter int SIZE_9           = 99,
    parameter int SIZE_address_wei = 13,
    parameter int SIZE_cnt         = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    conv_weight_packer_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0]          LANE_LAST = 4'd8;
    localparam logic [SIZE_cnt-1:0] CNT_ZERO  = {SIZE_cnt{1'b0}};
    localparam logic [SIZE_cnt-1:0] CNT_ONE   = {{(SIZE_cnt-1){1'b0}}, 1'b1};

    state_t                      state_r, state_s;
    logic [3:0]                  lane_r, lane_s;
    logic [SIZE_cnt-1:0]         word_r, word_s;
    logic [SIZE_cnt-1:0]         num_r, num_s;
    logic [SIZE_address_wei-1:0] base_r, base_s;
    logic [SIZE_9-1:0]           pack_r, pack_s;
    logic [SIZE_address_wei-1:0] addr_r, addr_s;
    logic [SIZE_9-1:0]           dw_r, dw_s;
    logic                        in_ready_r, in_ready_s;
    logic                        we_r, we_s;
    logic                        busy_r, busy_s;
    logic                        stop_r, stop_s;
    logic                        xfer_s;
    logic                        last_word_s;

    // Next-state, datapath and next-output decode.
    always_comb begin
        state_s     = state_r;
        lane_s      = lane_r;
        word_s      = word_r;
        num_s       = num_r;
        base_s      = base_r;
        pack_s      = pack_r;
        addr_s      = addr_r;
        dw_s        = dw_r;
        xfer_s      = bus.in_valid & in_ready_r;
        last_word_s = (word_r == (num_r - CNT_ONE));

        case (state_r)
            ST_IDLE: begin
                if (bus.load_en) begin
                    base_s = bus.memstartw;
                    num_s  = bus.num_words;
                    lane_s = 4'd0;
                    word_s = CNT_ZERO;
                    if (bus.num_words == CNT_ZERO) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_FILL;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (!bus.load_en) begin
                    state_s = ST_IDLE;
                end else if (xfer_s) begin
                    pack_s[lane_r*SIZE +: SIZE] = bus.in_data;
                    lane_s = lane_r + 4'd1;
                    // The write-cycle outputs are captured here so they are registered
                    // and already include the ninth coefficient.
                    if (lane_r == LANE_LAST) begin
                        state_s = ST_WRITE;
                        dw_s    = pack_s;
                        addr_s  = base_r + SIZE_address_wei'(word_r);
                    end else begin
                        state_s = ST_FILL;
                    end
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_WRITE: begin
                lane_s = 4'd0;
                word_s = word_r + CNT_ONE;
                if (!bus.load_en) begin
                    state_s = ST_IDLE;
                end else if (last_word_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_DONE: begin
                if (bus.load_en) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        in_ready_s = (state_s == ST_FILL);
        we_s       = (state_s == ST_WRITE);
        busy_s     = (state_s == ST_FILL) || (state_s == ST_WRITE);
        stop_s     = (state_s == ST_DONE);
    end

    // State, datapath and registered output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            lane_r     <= 4'd0;
            word_r     <= CNT_ZERO;
            num_r      <= CNT_ZERO;
            base_r     <= {SIZE_address_wei{1'b0}};
            pack_r     <= {SIZE_9{1'b0}};
            addr_r     <= {SIZE_address_wei{1'b0}};
            dw_r       <= {SIZE_9{1'b0}};
            in_ready_r <= 1'b0;
            we_r       <= 1'b0;
            busy_r     <= 1'b0;
            stop_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            lane_r     <= lane_s;
            word_r     <= word_s;
            num_r      <= num_s;
            base_r     <= base_s;
            pack_r     <= pack_s;
            addr_r     <= addr_s;
            dw_r       <= dw_s;
            in_ready_r <= in_ready_s;
            we_r       <= we_s;
            busy_r     <= busy_s;
            stop_r     <= stop_s;
        end
    end

    assign bus.in_ready       = in_ready_r;
    assign bus.we_w           = we_r;
    assign bus.write_addressw = addr_r;
    assign bus.dw             = dw_r;
    assign bus.STOP           = stop_r;
    assign bus.busy           = busy_r;

endmodule

// File: tb/tb_conv_weight_packer.sv
// Directed self-checking bench for conv_weight_packer: packing, address wrap, gaps,
// abort/restart, zero-word loads and reset in FILL and DONE.
module tb_conv_weight_packer;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    conv_weight_packer_if #(.SIZE(11), .SIZE_9(99), .SIZE_address_wei(13), .SIZE_cnt(10)) bus();

    conv_weight_packer #(.SIZE(11), .SIZE_9(99), .SIZE_address_wei(13), .SIZE_cnt(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [12:0] wr_addr [0:31];
    logic [98:0] wr_data [0:31];
    int          wr_n  = 0;
    int          acc_n = 0;
    int          rdy_n = 0;
    int          gaps [18] = '{0, 2, 1, 0, 3, 0, 1, 0, 2, 0, 1, 0, 0, 2, 1, 0, 0, 1};

    // Records RAM writes, accepted transfers and ready cycles as seen at each edge.
    always @(posedge clk) begin
        if (bus.we_w) begin
            wr_addr[wr_n] <= bus.write_addressw;
            wr_data[wr_n] <= bus.dw;
            wr_n          <= wr_n + 1;
        end
        if (bus.in_valid && bus.in_ready) acc_n <= acc_n + 1;
        if (bus.in_ready) rdy_n <= rdy_n + 1;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic c1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ca(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cw(input string tag, input logic [98:0] obs, input logic [98:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ci(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [10:0] c);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = c;
        while (!bus.in_ready && n < 50) begin
            step();
            n++;
        end
        c1("send_ready", bus.in_ready, 1'b1);
        step();
        bus.in_valid = 1'b0;
        bus.in_data  = 11'h7FF;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_data  = 11'h7FF;
        repeat (n) step();
    endtask

    task automatic wait_stop();
        int n = 0;
        while (!bus.STOP && n < 100) begin
            step();
            n++;
        end
        c1("stop_wait", bus.STOP, 1'b1);
    endtask

    task automatic check_reset(input string tag);
        c1({tag, "_ready"}, bus.in_ready, 1'b0);
        c1({tag, "_we"},    bus.we_w,     1'b0);
        c1({tag, "_stop"},  bus.STOP,     1'b0);
        c1({tag, "_busy"},  bus.busy,     1'b0);
        ca({tag, "_addr"},  bus.write_addressw, 13'd0);
        cw({tag, "_dw"},    bus.dw,       99'd0);
    endtask

    initial begin
        int w0;
        int r0;
        int a0;
        logic [10:0] c;

        rst           = 1'b1;
        bus.load_en   = 1'b0;
        bus.memstartw = 13'd0;
        bus.num_words = 10'd0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 11'd0;
        step();
        step();
        check_reset("reset");
        rst = 1'b0;

        // Single word at 100; base/count changes mid-load must be ignored.
        bus.memstartw = 13'd100;
        bus.num_words = 10'd1;
        bus.load_en   = 1'b1;
        w0 = wr_n;
        r0 = rdy_n;
        step();
        c1("t1_busy", bus.busy, 1'b1);
        c1("t1_ready", bus.in_ready, 1'b1);
        bus.memstartw = 13'd555;
        bus.num_words = 10'd7;
        for (int i = 1; i <= 9; i++) send(11'(i));
        c1("t1_we", bus.we_w, 1'b1);
        c1("t1_ready_wr", bus.in_ready, 1'b0);
        ca("t1_addr", bus.write_addressw, 13'd100);
        cw("t1_dw", bus.dw, {11'd9, 11'd8, 11'd7, 11'd6, 11'd5, 11'd4, 11'd3, 11'd2, 11'd1});
        step();
        c1("t1_stop", bus.STOP, 1'b1);
        c1("t1_we_off", bus.we_w, 1'b0);
        c1("t1_busy_off", bus.busy, 1'b0);
        cw("t1_dw_hold", bus.dw, {11'd9, 11'd8, 11'd7, 11'd6, 11'd5, 11'd4, 11'd3, 11'd2, 11'd1});
        ci("t1_rdy_cycles", rdy_n - r0, 9);
        ci("t1_writes", wr_n - w0, 1);
        bus.load_en = 1'b0;
        step();
        c1("t1_stop_clr", bus.STOP, 1'b0);

        // Three words from 8190: address wraps, negative lanes are bit-exact.
        bus.memstartw = 13'd8190;
        bus.num_words = 10'd3;
        bus.load_en   = 1'b1;
        w0 = wr_n;
        step();
        c = 11'h400;
        for (int i = 0; i < 27; i++) begin
            send(c);
            c = c + 11'd1;
        end
        wait_stop();
        ci("t2_writes", wr_n - w0, 3);
        ca("t2_addr0", wr_addr[w0],     13'd8190);
        ca("t2_addr1", wr_addr[w0 + 1], 13'd8191);
        ca("t2_addr2", wr_addr[w0 + 2], 13'd0);
        cw("t2_lane0", {88'd0, wr_data[w0][10:0]}, {88'd0, 11'h400});
        cw("t2_word0", wr_data[w0],
           {11'h408, 11'h407, 11'h406, 11'h405, 11'h404, 11'h403, 11'h402, 11'h401, 11'h400});
        cw("t2_word1", wr_data[w0 + 1],
           {11'h411, 11'h410, 11'h40F, 11'h40E, 11'h40D, 11'h40C, 11'h40B, 11'h40A, 11'h409});
        cw("t2_word2", wr_data[w0 + 2],
           {11'h41A, 11'h419, 11'h418, 11'h417, 11'h416, 11'h415, 11'h414, 11'h413, 11'h412});
        bus.load_en = 1'b0;
        step();

        // Gappy valid; a coefficient offered during WRITE waits for FILL.
        bus.memstartw = 13'd40;
        bus.num_words = 10'd2;
        bus.load_en   = 1'b1;
        w0 = wr_n;
        a0 = acc_n;
        step();
        for (int i = 1; i <= 9; i++) begin
            idle(gaps[i-1]);
            send(11'(i));
        end
        c1("t3_we", bus.we_w, 1'b1);
        c1("t3_ready_wr", bus.in_ready, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 11'd10;
        step();
        ci("t3_acc_wr", acc_n - a0, 9);
        c1("t3_ready_fill", bus.in_ready, 1'b1);
        step();
        bus.in_valid = 1'b0;
        for (int i = 11; i <= 18; i++) begin
            idle(gaps[i-1]);
            send(11'(i));
        end
        wait_stop();
        ci("t3_acc", acc_n - a0, 18);
        ci("t3_writes", wr_n - w0, 2);
        ca("t3_addr0", wr_addr[w0],     13'd40);
        ca("t3_addr1", wr_addr[w0 + 1], 13'd41);
        cw("t3_word0", wr_data[w0],
           {11'd9, 11'd8, 11'd7, 11'd6, 11'd5, 11'd4, 11'd3, 11'd2, 11'd1});
        cw("t3_word1", wr_data[w0 + 1],
           {11'd18, 11'd17, 11'd16, 11'd15, 11'd14, 11'd13, 11'd12, 11'd11, 11'd10});
        bus.load_en = 1'b0;
        step();

        // Abort after 5 coefficients, then restart with a fresh word.
        bus.memstartw = 13'd200;
        bus.num_words = 10'd1;
        bus.load_en   = 1'b1;
        w0 = wr_n;
        step();
        for (int i = 1; i <= 5; i++) send(11'(i + 100));
        bus.load_en = 1'b0;
        step();
        c1("t4_busy", bus.busy, 1'b0);
        c1("t4_ready", bus.in_ready, 1'b0);
        c1("t4_stop", bus.STOP, 1'b0);
        c1("t4_we", bus.we_w, 1'b0);
        step();
        ci("t4_no_write", wr_n - w0, 0);
        bus.memstartw = 13'd300;
        bus.num_words = 10'd1;
        bus.load_en   = 1'b1;
        step();
        for (int i = 21; i <= 29; i++) send(11'(i));
        wait_stop();
        ci("t4_writes", wr_n - w0, 1);
        ca("t4_addr", wr_addr[w0], 13'd300);
        cw("t4_word", wr_data[w0],
           {11'd29, 11'd28, 11'd27, 11'd26, 11'd25, 11'd24, 11'd23, 11'd22, 11'd21});
        bus.load_en = 1'b0;
        step();

        // Zero-word load goes straight to DONE.
        bus.memstartw = 13'd5;
        bus.num_words = 10'd0;
        bus.load_en   = 1'b1;
        w0 = wr_n;
        r0 = rdy_n;
        step();
        c1("t5_stop", bus.STOP, 1'b1);
        c1("t5_ready", bus.in_ready, 1'b0);
        c1("t5_busy", bus.busy, 1'b0);
        step();
        step();
        c1("t5_stop_hold", bus.STOP, 1'b1);
        ci("t5_no_ready", rdy_n - r0, 0);
        ci("t5_no_write", wr_n - w0, 0);
        bus.load_en = 1'b0;
        step();
        c1("t5_stop_clr", bus.STOP, 1'b0);

        // Reset in mid-FILL (with load_en still high) and again in DONE.
        bus.memstartw = 13'd60;
        bus.num_words = 10'd1;
        bus.load_en   = 1'b1;
        w0 = wr_n;
        step();
        for (int i = 1; i <= 4; i++) send(11'(i + 50));
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 11'd55;
        step();
        check_reset("t6_fill");
        rst          = 1'b0;
        bus.load_en  = 1'b0;
        bus.in_valid = 1'b0;
        step();
        step();
        ci("t6_no_write", wr_n - w0, 0);
        c1("t6_idle_busy", bus.busy, 1'b0);
        bus.num_words = 10'd0;
        bus.load_en   = 1'b1;
        step();
        c1("t6_done_stop", bus.STOP, 1'b1);
        rst = 1'b1;
        step();
        check_reset("t6_done");
        rst         = 1'b0;
        bus.load_en = 1'b0;
        step();
        c1("t6_after_stop", bus.STOP, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
